// File: rtl/engine_clause_queue.sv
// engine_clause_queue
//   Per-engine clause buffer placed directly after the distribution unit.
//   There is one instance for each BCP engine. The block takes the engine's
//   clause slice when the engine's grant bit is set, and reports back through
//   full_out. It offers the queued clauses to the engine, and separately the
//   most recent chosen unit clause (UC). Both use valid/ready handshakes.
//
// Ports
//   clock, reset            clock; synchronous active-low reset
//   clause_in, grant_in     clause slice and push request from the distribution unit
//   full_out, count_out     queue full flag (to full_in[engine]) and occupancy
//   flush_in                discard every queued clause
//   clause_out, clause_valid_out, clause_ready_in   head-of-queue handshake
//   uc_in, uc_valid_in      chosen unit clause from the distribution unit
//   uc_out, uc_valid_out, uc_ready_in               held-UC handshake
//   overflow_err            sticky flag: a grant arrived while the queue was full
module engine_clause_queue #(
    parameter int LIT_IDX_MAX = 1024,
    parameter int CLA_LENGTH  = 3,
    parameter int DEPTH       = 8,
    localparam int VAR_W = $clog2(LIT_IDX_MAX) + 1,
    localparam int CLA_W = CLA_LENGTH * VAR_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CLA_W-1:0] clause_in,
    input  logic             grant_in,
    output logic             full_out,
    output logic [CNT_W-1:0] count_out,
    input  logic             flush_in,
    output logic [CLA_W-1:0] clause_out,
    output logic             clause_valid_out,
    input  logic             clause_ready_in,
    input  logic [VAR_W-1:0] uc_in,
    input  logic             uc_valid_in,
    output logic [VAR_W-1:0] uc_out,
    output logic             uc_valid_out,
    input  logic             uc_ready_in,
    output logic             overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CLA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [VAR_W-1:0] uc_q, uc_d;
    logic             uc_vld_q, uc_vld_d;
    logic             ovf_q, ovf_d;
    logic             push, pop;

    // full_out comes only from the registered count. A pop in the same cycle
    // therefore cannot make room for a grant that arrives while full.
    assign full_out         = (count_q == FULL_CNT);
    assign clause_valid_out = (count_q != '0);
    assign count_out        = count_q;
    assign clause_out       = mem_q[rd_ptr_q];
    assign uc_out           = uc_q;
    assign uc_valid_out     = uc_vld_q;
    assign overflow_err     = ovf_q;

    assign push = grant_in && !full_out;
    assign pop  = clause_valid_out && clause_ready_in;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        uc_d     = uc_q;
        uc_vld_d = uc_vld_q;
        ovf_d    = ovf_q;

        if (flush_in) begin
            // A flush takes priority over any push or pop in the same cycle.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (grant_in && full_out) ovf_d = 1'b1;

        // A newly loaded UC takes priority over the consume of the old one.
        if (uc_valid_in) begin
            uc_d     = uc_in;
            uc_vld_d = 1'b1;
        end else if (uc_vld_q && uc_ready_in) begin
            uc_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            uc_q     <= '0;
            uc_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            uc_q     <= uc_d;
            uc_vld_q <= uc_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset. A flushed push is not written, which keeps it
    // out of the queue.
    always_ff @(posedge clock) begin
        if (push && !flush_in) mem_q[wr_ptr_q] <= clause_in;
    end

endmodule

// File: tb/tb_engine_clause_queue.sv
module tb_engine_clause_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [32:0] clause_in;
    logic        grant_in;
    logic        full_out;
    logic [3:0]  count_out;
    logic        flush_in;
    logic [32:0] clause_out;
    logic        clause_valid_out;
    logic        clause_ready_in;
    logic [10:0] uc_in;
    logic        uc_valid_in;
    logic [10:0] uc_out;
    logic        uc_valid_out;
    logic        uc_ready_in;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;

    engine_clause_queue dut (
        .clock            (clock),
        .reset            (reset),
        .clause_in        (clause_in),
        .grant_in         (grant_in),
        .full_out         (full_out),
        .count_out        (count_out),
        .flush_in         (flush_in),
        .clause_out       (clause_out),
        .clause_valid_out (clause_valid_out),
        .clause_ready_in  (clause_ready_in),
        .uc_in            (uc_in),
        .uc_valid_in      (uc_valid_in),
        .uc_out           (uc_out),
        .uc_valid_out     (uc_valid_out),
        .uc_ready_in      (uc_ready_in),
        .overflow_err     (overflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        grant;
        logic [32:0] cla;
        logic        rdy;
        logic        flush;
        logic [10:0] uc;
        logic        ucv;
        logic        ucr;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_vld;
        logic [32:0] e_cla;
        logic [10:0] e_uc;
        logic        e_ucv;
        logic        e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int grant, input int cla, input int rdy, input int flush,
                       input int uc, input int ucv, input int ucr,
                       input int e_cnt, input int e_full, input int e_vld, input int e_cla,
                       input int e_uc, input int e_ucv, input int e_ovf);
        vec_t v;
        v.grant  = 1'(grant);
        v.cla    = 33'(cla);
        v.rdy    = 1'(rdy);
        v.flush  = 1'(flush);
        v.uc     = 11'(uc);
        v.ucv    = 1'(ucv);
        v.ucr    = 1'(ucr);
        v.e_cnt  = 4'(e_cnt);
        v.e_full = 1'(e_full);
        v.e_vld  = 1'(e_vld);
        v.e_cla  = 33'(e_cla);
        v.e_uc   = 11'(e_uc);
        v.e_ucv  = 1'(e_ucv);
        v.e_ovf  = 1'(e_ovf);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        grant_in = 0; clause_in = '0; clause_ready_in = 0; flush_in = 0;
        uc_in = '0; uc_valid_in = 0; uc_ready_in = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset = 0;

        // ---- reset ----
        step();
        step();
        reset = 1;
        chk("rst_full", 64'(full_out), 64'(0));
        chk("rst_vld", 64'(clause_valid_out), 64'(0));
        chk("rst_ucv", 64'(uc_valid_out), 64'(0));
        chk("rst_ovf", 64'(overflow_err), 64'(0));
        chk("rst_cnt", 64'(count_out), 64'(0));
        chk("rst_uc", 64'(uc_out), 64'(0));

        // ---- no same-cycle bypass into an empty queue ----
        grant_in = 1; clause_in = 33'd5;
        #2;
        chk("nobypass_vld", 64'(clause_valid_out), 64'(0));
        step();
        grant_in = 0;
        chk("push1_vld", 64'(clause_valid_out), 64'(1));
        chk("push1_cla", 64'(clause_out), 64'(5));
        clause_ready_in = 1;
        step();
        clause_ready_in = 0;
        chk("pop1_vld", 64'(clause_valid_out), 64'(0));

        // ---- vector table ----
        // fill 0..7 with ready low
        for (int i = 0; i < 8; i++)
            add(1, i, 0, 0, 0, 0, 0, i + 1, int'(i == 7), 1, 0, 0, 0, 0);
        // grant while full, plus a pop: the pop happens, 99 is dropped
        add(1, 99, 1, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 1);
        // drain 1..7
        for (int j = 1; j < 8; j++)
            add(0, 0, 1, 0, 0, 0, 0, 7 - j, 0, int'(j < 7), j + 1, 0, 0, 1);
        // count=3, then 10 cycles of push+pop with pointer wrap
        for (int k = 0; k < 3; k++)
            add(1, 7 + k, 0, 0, 0, 0, 0, k + 1, 0, 1, 7, 0, 0, 1);
        for (int k = 0; k < 10; k++)
            add(1, 10 + k, 1, 0, 0, 0, 0, 3, 0, 1, 8 + k, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            add(0, 0, 1, 0, 0, 0, 0, 2 - k, 0, int'(k < 2), 18 + k, 0, 0, 1);
        // count=5, then flush with a grant, then push 42
        for (int k = 0; k < 5; k++)
            add(1, 50 + k, 0, 0, 0, 0, 0, k + 1, 0, 1, 50, 0, 0, 1);
        add(1, 77, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 42, 0, 0, 0, 0, 0, 1, 0, 1, 42, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // UC register
        add(0, 0, 0, 0, 'h5BB, 1, 0, 0, 0, 0, 0, 'h5BB, 1, 1);
        add(0, 0, 0, 0, 'h123, 1, 0, 0, 0, 0, 0, 'h123, 1, 1);
        add(0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 'h123, 0, 1);
        add(0, 0, 0, 0, 'h0AA, 1, 0, 0, 0, 0, 0, 'h0AA, 1, 1);
        add(0, 0, 0, 1, 0,     0, 0, 0, 0, 0, 0, 'h0AA, 1, 1);
        add(0, 0, 0, 0, 'h055, 1, 1, 0, 0, 0, 0, 'h055, 1, 1);
        add(0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 'h055, 0, 1);

        foreach (vq[n]) begin
            grant_in        = vq[n].grant;
            clause_in       = vq[n].cla;
            clause_ready_in = vq[n].rdy;
            flush_in        = vq[n].flush;
            uc_in           = vq[n].uc;
            uc_valid_in     = vq[n].ucv;
            uc_ready_in     = vq[n].ucr;
            step();
            chk($sformatf("v%0d_cnt", n), 64'(count_out), 64'(vq[n].e_cnt));
            chk($sformatf("v%0d_full", n), 64'(full_out), 64'(vq[n].e_full));
            chk($sformatf("v%0d_vld", n), 64'(clause_valid_out), 64'(vq[n].e_vld));
            if (vq[n].e_vld)
                chk($sformatf("v%0d_cla", n), 64'(clause_out), 64'(vq[n].e_cla));
            chk($sformatf("v%0d_uc", n), 64'(uc_out), 64'(vq[n].e_uc));
            chk($sformatf("v%0d_ucv", n), 64'(uc_valid_out), 64'(vq[n].e_ucv));
            chk($sformatf("v%0d_ovf", n), 64'(overflow_err), 64'(vq[n].e_ovf));
        end
        idle();

        // ---- grant while full with no pop: count holds at 8 ----
        for (int i = 0; i < 8; i++) begin
            grant_in = 1; clause_in = 33'(200 + i);
            step();
        end
        clause_in = 33'd300;
        step();
        grant_in = 0;
        chk("full_hold_cnt", 64'(count_out), 64'(8));
        chk("full_hold_full", 64'(full_out), 64'(1));
        chk("full_hold_head", 64'(clause_out), 64'(200));

        // ---- reset clears the sticky error and the UC ----
        uc_in = 11'h3C3; uc_valid_in = 1;
        step();
        uc_valid_in = 0;
        chk("uc_pre_rst", 64'(uc_out), 64'('h3C3));
        reset = 0; grant_in = 1;
        step();
        reset = 1; grant_in = 0;
        chk("rst2_ovf", 64'(overflow_err), 64'(0));
        chk("rst2_cnt", 64'(count_out), 64'(0));
        chk("rst2_uc", 64'(uc_out), 64'(0));
        chk("rst2_ucv", 64'(uc_valid_out), 64'(0));
        chk("rst2_full", 64'(full_out), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
